// File: rtl/instr_mem_fetch_unit.sv
// instr_mem_fetch_unit: instruction memory that feeds the IF stage.
// There are three states:
//   CLEAR scrubs every word to zero.
//   LOAD  accepts program words on a valid/ready port.
//   RUN   serves one registered fetch per cycle, with stall, flush and fault reporting.
// Optional build macro INSTR_MEM_BYTE_WE_EN adds the i_load_be per-byte write enables.
module instr_mem_fetch_unit #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DEPTH_WORDS = 256,
   parameter logic [DATA_W-1:0] NOP_INSTR   = DATA_W'(32'h00000013)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_load_start,
   input  logic                i_load_valid,
   output logic                o_load_ready,
   input  logic [ADDR_W-1:0]   i_load_addr,
   input  logic [DATA_W-1:0]   i_load_data,
`ifdef INSTR_MEM_BYTE_WE_EN
   input  logic [DATA_W/8-1:0] i_load_be,
`endif
   input  logic                i_load_done,
   output logic                o_load_err,
   input  logic                i_fetch_req,
   input  logic                i_fetch_stall,
   input  logic                i_fetch_flush,
   input  logic [ADDR_W-1:0]   i_fetch_addr,
   output logic [DATA_W-1:0]   o_instr_out,
   output logic [ADDR_W-1:0]   o_instr_pc,
   output logic                o_instr_valid,
   output logic                o_fetch_fault,
   output logic                o_run
);

   localparam int unsigned       BYTES    = DATA_W / 8;
   localparam int unsigned       OFF_SH   = $clog2(BYTES);
   localparam int unsigned       IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH_WORDS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // An address is bad when it is not word aligned or when it points past the last word.
   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      return ((a & OFF_MASK) != '0) || ((a >> OFF_SH) >= DEPTH_A);
   endfunction

   // Returns the word index of a byte address.
   // It is meaningful only when addr_bad() is false.
   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] w_word;
      w_word = a >> OFF_SH;
      return w_word[IDX_W-1:0];
   endfunction

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   state_t            r_state;
   logic [IDX_W-1:0]  r_clr_cnt;
   logic              r_load_ready;
   logic              r_load_err;
   logic [DATA_W-1:0] r_instr_out;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid;
   logic              r_fetch_fault;
   logic              r_run;

   logic              w_load_bad;
   logic [IDX_W-1:0]  w_load_idx;
   logic              w_fetch_bad;
   logic [IDX_W-1:0]  w_fetch_idx;
   logic              w_we;
   logic [IDX_W-1:0]  w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [BYTES-1:0]  w_wbe;

   assign w_load_bad  = addr_bad(i_load_addr);
   assign w_load_idx  = addr_idx(i_load_addr);
   assign w_fetch_bad = addr_bad(i_fetch_addr);
   assign w_fetch_idx = addr_idx(i_fetch_addr);

   // Selects the single memory write port source.
   // In CLEAR the source is the scrub counter; in LOAD it is an accepted good-address load word.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_clr_cnt;
      w_wdata = '0;
      w_wbe   = '1;
      case (r_state)
         ST_CLEAR: begin
            w_we = ~i_reset;
         end
         ST_LOAD: begin
            if (i_load_valid && !w_load_bad && !i_reset) begin
               w_we    = 1'b1;
               w_waddr = w_load_idx;
               w_wdata = i_load_data;
`ifdef INSTR_MEM_BYTE_WE_EN
               w_wbe   = i_load_be;
`else
               w_wbe   = '1;
`endif
            end else begin
               w_we = 1'b0;
            end
         end
         default: begin
            w_we = 1'b0;
         end
      endcase
   end

   // Writes the memory array, one byte lane at a time.
   // The array has no reset; the CLEAR state scrubs it instead.
   always_ff @(posedge i_clk) begin
      if (w_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (w_wbe[b]) begin
               r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   // Runs the CLEAR/LOAD/RUN state machine and drives all registered outputs.
   // It also performs the synchronous fetch read.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_CLEAR;
         r_clr_cnt     <= '0;
         r_load_ready  <= 1'b0;
         r_load_err    <= 1'b0;
         r_instr_out   <= NOP_INSTR;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_run         <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + IDX_W'(1);
               if (r_clr_cnt == LAST_IDX) begin
                  r_state      <= ST_LOAD;
                  r_load_ready <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (i_load_valid && w_load_bad) begin
                  r_load_err <= 1'b1;
               end
               if (i_load_done) begin
                  r_state      <= ST_RUN;
                  r_load_ready <= 1'b0;
                  r_run        <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_load_start) begin
                  // Going back to LOAD invalidates whatever the fetch stage was presenting.
                  r_state       <= ST_LOAD;
                  r_load_ready  <= 1'b1;
                  r_run         <= 1'b0;
                  r_instr_out   <= NOP_INSTR;
                  r_instr_valid <= 1'b0;
                  r_fetch_fault <= 1'b0;
               end else if (i_fetch_flush) begin
                  r_instr_out   <= NOP_INSTR;
                  r_instr_valid <= 1'b0;
                  r_fetch_fault <= 1'b0;
               end else if (i_fetch_stall) begin
                  r_instr_out   <= r_instr_out;
               end else if (i_fetch_req) begin
                  r_instr_out   <= w_fetch_bad ? NOP_INSTR : r_mem[w_fetch_idx];
                  r_instr_pc    <= i_fetch_addr;
                  r_instr_valid <= 1'b1;
                  r_fetch_fault <= w_fetch_bad;
               end else begin
                  r_instr_out   <= NOP_INSTR;
                  r_instr_valid <= 1'b0;
                  r_fetch_fault <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_CLEAR;
               r_clr_cnt    <= '0;
               r_load_ready <= 1'b0;
               r_run        <= 1'b0;
            end
         endcase
      end
   end

   assign o_load_ready  = r_load_ready;
   assign o_load_err    = r_load_err;
   assign o_instr_out   = r_instr_out;
   assign o_instr_pc    = r_instr_pc;
   assign o_instr_valid = r_instr_valid;
   assign o_fetch_fault = r_fetch_fault;
   assign o_run         = r_run;

endmodule

// File: doc/instr_mem_fetch_unit.md
Name: instr_mem_fetch_unit

Overview:
Parametrised instruction memory with a programming (load) port and a pipelined fetch port for the five-stage core's IF stage.
- A clear/load/run state machine replaces reset-loop initialisation with a sequential memory scrub.
- Program words are written through a valid/ready handshake at byte addresses.
- The fetch port returns one instruction per cycle, with stall, flush, misalignment and out-of-range fault reporting.

Parameters:
DATA_W, 32, instruction/data word width in bits (multiple of 8)
ADDR_W, 32, byte-address width of load_addr and fetch_addr
DEPTH_WORDS, 256, memory depth in words (power of two, >= 4)
NOP_INSTR, 32'h00000013, value driven on instr_out when no valid instruction is presented

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  request re-entry to LOAD from RUN
load_valid  in  1  load word presented
load_ready  out  1  high in LOAD state
load_addr  in  ADDR_W  byte address of load word
load_data  in  DATA_W  load word
load_done  in  1  end of programming
load_err  out  1  sticky: a dropped (bad-address) load occurred
fetch_req  in  1  fetch request
fetch_stall  in  1  hold fetch output
fetch_flush  in  1  kill fetch output
fetch_addr  in  ADDR_W  byte address (PC)
instr_out  out  DATA_W  fetched instruction
instr_pc  out  ADDR_W  PC of instr_out
instr_valid  out  1  instr_out is meaningful
fetch_fault  out  1  qualifies instr_valid: misaligned or out-of-range PC
run  out  1  high in RUN state

Behaviour:
- Reset values:
  - load_ready=0, load_err=0, instr_out=NOP_INSTR, instr_pc=0, instr_valid=0, fetch_fault=0, run=0.
  - State=CLEAR, clear counter=0.
- Reset is asserted on any cycle, including mid-LOAD or mid-RUN: all outputs and state return to their reset values on the next edge. Memory is re-scrubbed by CLEAR.
- Word index = addr >> log2(DATA_W/8). An address is bad if its low byte-offset bits are nonzero, or if the word index is >= DEPTH_WORDS.
- CLEAR:
  - Writes 0 to word[counter] each cycle; counter increments.
  - When counter == DEPTH_WORDS-1 the final write occurs and the next state is LOAD. CLEAR therefore lasts exactly DEPTH_WORDS cycles.
  - All inputs are ignored.
- LOAD:
  - load_ready=1. A write occurs when load_valid && load_ready.
  - Good address: word[index] <= load_data.
  - Bad address: write dropped, load_err <= 1. load_err stays set until reset.
  - load_done moves the state to RUN on the next edge. If load_valid and load_done are asserted in the same cycle, the write is performed, then RUN.
  - Fetch inputs are ignored; instr_valid=0.
- RUN:
  - run=1, load_ready=0; load_valid is ignored.
  - load_start moves the state to LOAD on the next edge, memory is retained, and instr_valid is forced to 0 from that edge onward.
- Fetch (RUN only), 1-cycle registered latency. Priority is flush > stall > req:
  - fetch_flush: instr_out=NOP_INSTR, instr_valid=0, fetch_fault=0.
  - fetch_stall (no flush): all fetch outputs hold their values.
  - fetch_req, good addr: instr_out=word[index], instr_pc=fetch_addr, instr_valid=1, fetch_fault=0.
  - fetch_req, bad addr: instr_out=NOP_INSTR, instr_pc=fetch_addr, instr_valid=1, fetch_fault=1.
  - No req: instr_out=NOP_INSTR, instr_valid=0, fetch_fault=0; instr_pc holds.
- Memory access is synchronous, with no combinational read path from fetch_addr to instr_out.
- The load and fetch ports are never active in the same state, so there is no read/write collision.

Optional Feature:
INSTR_MEM_BYTE_WE_EN
- Defined: adds input port load_be, width DATA_W/8. An accepted good-address load writes only the bytes whose load_be bit is 1. load_be == 0 is a legal no-op write and does not set load_err. CLEAR still zeroes full words.
- Undefined: load_be is absent and every accepted load writes the full word.

Test Plan:
1. Release reset with DEPTH_WORDS=256 -> load_ready rises exactly 256 cycles after the first non-reset edge; run=0 throughout; fetch of any word after load_done returns 0.
2. Load addr 0x0 <= 0x00500093 and addr 0x4 <= 0x00108113, then load_done; fetch_addr 0x4 in RUN -> one cycle later instr_out=0x00108113, instr_pc=0x4, instr_valid=1, fetch_fault=0.
3. Load to addr 0x2 and to addr 0x400 (DEPTH_WORDS=256) -> neither write lands and load_err=1 until reset; a fetch of 0x2 yields instr_valid=1, fetch_fault=1, instr_out=0x00000013.
4. Streaming fetches 0x0, 0x4 with fetch_stall on the second cycle -> outputs hold 0x00500093/PC 0x0 for the stalled cycle, then 0x00108113. Asserting fetch_flush together with stall -> instr_valid=0, instr_out=0x00000013.
5. Assert reset mid-LOAD after two writes -> outputs at reset values, CLEAR re-runs for 256 cycles, and previously loaded words read back as 0.
6. With INSTR_MEM_BYTE_WE_EN: word 0x0 holds 0xAABBCCDD; load 0x11223344 with load_be=4'b0101 -> fetch 0x0 returns 0xAA22CC44.
